// File: rtl/accel_arb_pkg.sv
// Shared constants and types for the accelerator MMIO port arbiter.
package accel_arb_pkg;

  localparam int REQ_DMA  = 0;
  localparam int REQ_PCPI = 1;
  localparam int REQ_CPU  = 2;
  localparam int NUM_REQ  = 3;

  localparam logic [1:0]  GRANT_NONE = 2'd3;
  localparam logic [31:0] ERR_RDATA  = 32'hDEADBEEF;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  function automatic logic [1:0] lowest_set(input logic [NUM_REQ-1:0] v);
    logic [1:0] idx;
    idx = GRANT_NONE;
    if (v[REQ_DMA])       idx = 2'(REQ_DMA);
    else if (v[REQ_PCPI]) idx = 2'(REQ_PCPI);
    else if (v[REQ_CPU])  idx = 2'(REQ_CPU);
    return idx;
  endfunction

endpackage

// File: rtl/accel_port_arbiter_starve.sv
// Per-requester lost-arbitration counter; saturates at the limit and flags starvation.
module arb_starve_ctr #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic lost,
  input  logic won,
  output logic starved
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (won)                        cnt_d = '0;
    else if (lost && cnt_q < LIMIT) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign starved = (cnt_q >= LIMIT);

endmodule

// File: rtl/accel_port_arbiter.sv
// Three-way arbiter for the accelerator MMIO port with starvation aging and bus timeout.
//   state    | meaning
//   ARB_IDLE | port free; arbitrate among valid requesters and latch winner payload
//   ARB_BUSY | payload presented to accelerator; wait for ready or timeout abort
module accel_port_arbiter
  import accel_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned STARVE_LIMIT   = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  req_valid,
  input  logic [2:0]  req_write,
  input  logic [95:0] req_addr,
  input  logic [95:0] req_wdata,
  input  logic [11:0] req_wstrb,
  output logic [2:0]  req_ready,
  output logic [2:0]  req_err,
  output logic [31:0] req_rdata,
  output logic        accel_mem_valid,
  output logic        accel_mem_write,
  output logic [31:0] accel_mem_addr,
  output logic [31:0] accel_mem_wdata,
  output logic [3:0]  accel_mem_wstrb,
  input  logic [31:0] accel_mem_rdata,
  input  logic        accel_mem_ready,
  output logic [1:0]  grant_id,
  output logic        busy,
  output logic [7:0]  timeout_count
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  arb_state_t  state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [15:0] tmo_q, tmo_d;
  logic [7:0]  tcnt_q, tcnt_d;

  logic [NUM_REQ-1:0] starved, lost, won;
  logic [1:0]         winner;
  logic               arb_fire, abort;

  // Starved requesters pre-empt fixed priority; lowest index still breaks ties among them.
  always_comb begin
    winner = (|(req_valid & starved)) ? lowest_set(req_valid & starved)
                                      : lowest_set(req_valid);
  end

  assign arb_fire = (state_q == ARB_IDLE) && (|req_valid);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_starve
    assign won[i]  = arb_fire && (winner == 2'(i));
    assign lost[i] = arb_fire && req_valid[i] && (winner != 2'(i));

    arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_ctr (
      .clk     (clk),
      .resetn  (resetn),
      .lost    (lost[i]),
      .won     (won[i]),
      .starved (starved[i])
    );
  end

  assign busy  = (state_q == ARB_BUSY);
  assign abort = busy && !accel_mem_ready && (tmo_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    tmo_d     = tmo_q;
    tcnt_d    = tcnt_q;
    req_ready = '0;
    req_err   = '0;
    req_rdata = '0;
    case (state_q)
      ARB_IDLE: begin
        if (arb_fire) begin
          state_d = ARB_BUSY;
          grant_d = winner;
          write_d = req_write[winner];
          addr_d  = req_addr[32*int'(winner) +: 32];
          wdata_d = req_wdata[32*int'(winner) +: 32];
          wstrb_d = req_wstrb[4*int'(winner) +: 4];
          tmo_d   = '0;
        end
      end
      ARB_BUSY: begin
        tmo_d = tmo_q + 16'd1;
        // A ready arriving on the abort cycle is a normal completion.
        if (accel_mem_ready) begin
          state_d   = ARB_IDLE;
          req_ready = 3'b001 << grant_q;
          req_rdata = accel_mem_rdata;
        end else if (abort) begin
          state_d   = ARB_IDLE;
          req_ready = 3'b001 << grant_q;
          req_err   = 3'b001 << grant_q;
          req_rdata = ERR_RDATA;
          if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ARB_IDLE;
      grant_q <= GRANT_NONE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      tmo_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      tmo_q   <= tmo_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign accel_mem_valid = busy;
  assign accel_mem_write = busy && write_q;
  assign accel_mem_addr  = busy ? addr_q  : '0;
  assign accel_mem_wdata = busy ? wdata_q : '0;
  assign accel_mem_wstrb = busy ? wstrb_q : '0;
  assign grant_id        = busy ? grant_q : GRANT_NONE;
  assign timeout_count   = tcnt_q;

endmodule

// File: tb/tb_accel_port_arbiter.sv
// Self-checking bench for accel_port_arbiter: vector table, directed corner cases, random vs. model.
module tb_accel_port_arbiter;

  localparam int TMO   = 16;
  localparam int STARV = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  req_valid, req_write;
  logic [95:0] req_addr, req_wdata;
  logic [11:0] req_wstrb;
  logic [2:0]  req_ready, req_err;
  logic [31:0] req_rdata;
  logic        accel_mem_valid, accel_mem_write;
  logic [31:0] accel_mem_addr, accel_mem_wdata;
  logic [3:0]  accel_mem_wstrb;
  logic [31:0] accel_mem_rdata;
  logic        accel_mem_ready;
  logic [1:0]  grant_id;
  logic        busy;
  logic [7:0]  timeout_count;

  logic [31:0] t_addr[3], t_wdata[3];
  logic [3:0]  t_wstrb[3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    for (int i = 0; i < 3; i++) begin
      req_addr[32*i +: 32] = t_addr[i];
      req_wdata[32*i +: 32] = t_wdata[i];
      req_wstrb[4*i +: 4]   = t_wstrb[i];
    end
  end

  accel_port_arbiter #(.TIMEOUT_CYCLES(TMO), .STARVE_LIMIT(STARV)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_ready(req_ready), .req_err(req_err), .req_rdata(req_rdata),
    .accel_mem_valid(accel_mem_valid), .accel_mem_write(accel_mem_write),
    .accel_mem_addr(accel_mem_addr), .accel_mem_wdata(accel_mem_wdata),
    .accel_mem_wstrb(accel_mem_wstrb), .accel_mem_rdata(accel_mem_rdata),
    .accel_mem_ready(accel_mem_ready), .grant_id(grant_id), .busy(busy),
    .timeout_count(timeout_count)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req_valid = '0;
    req_write = '0;
    accel_mem_ready = 1'b0;
    accel_mem_rdata = '0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  typedef struct {
    logic        rstn;
    logic [2:0]  v;
    logic        rdy;
    logic [31:0] rd;
    logic        ev;
    logic [1:0]  eg;
    logic [2:0]  er;
    logic [31:0] erd;
    logic [31:0] ea;
  } vec_t;

  vec_t tbl[8];

  // reference model state
  bit          m_busy;
  int          m_g, m_cnt, m_tcnt, m_w;
  int          m_starve[3];
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_write;
  bit          mv[3], dropped[3];
  bit          fin;
  logic [2:0]  e_ready, e_err;
  logic [31:0] e_rdata;

  int dma_grants, hit;
  bit cpu_seen;

  initial begin
    t_addr  = '{32'h1000_0000, 32'h1000_0100, 32'h1000_0200};
    t_wdata = '{32'hA0A0_0000, 32'hA1A1_0001, 32'hA2A2_0002};
    t_wstrb = '{4'hF, 4'h3, 4'hC};
    do_reset();

    // DMA and CPU collide: DMA first, CPU at the following arbitration
    tbl[0] = '{1'b0, 3'b000, 1'b0, 32'h0,         1'b0, 2'd3, 3'b000, 32'h0,         32'h0};
    tbl[1] = '{1'b1, 3'b101, 1'b0, 32'h0,         1'b0, 2'd3, 3'b000, 32'h0,         32'h0};
    tbl[2] = '{1'b1, 3'b101, 1'b1, 32'hAAAA_0001, 1'b1, 2'd0, 3'b001, 32'hAAAA_0001, 32'h1000_0000};
    tbl[3] = '{1'b1, 3'b100, 1'b0, 32'h0,         1'b0, 2'd3, 3'b000, 32'h0,         32'h0};
    tbl[4] = '{1'b1, 3'b100, 1'b0, 32'h77,        1'b1, 2'd2, 3'b000, 32'h0,         32'h1000_0200};
    tbl[5] = '{1'b1, 3'b100, 1'b1, 32'h5555_0002, 1'b1, 2'd2, 3'b100, 32'h5555_0002, 32'h1000_0200};
    tbl[6] = '{1'b1, 3'b000, 1'b0, 32'h0,         1'b0, 2'd3, 3'b000, 32'h0,         32'h0};
    tbl[7] = '{1'b1, 3'b000, 1'b0, 32'h0,         1'b0, 2'd3, 3'b000, 32'h0,         32'h0};
    for (int i = 0; i < 8; i++) begin
      resetn = tbl[i].rstn;
      req_valid = tbl[i].v;
      accel_mem_ready = tbl[i].rdy;
      accel_mem_rdata = tbl[i].rd;
      @(negedge clk);
      chk($sformatf("tbl%0d valid", i), 64'(accel_mem_valid), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d grant", i), 64'(grant_id), 64'(tbl[i].eg));
      chk($sformatf("tbl%0d ready", i), 64'(req_ready), 64'(tbl[i].er));
      chk($sformatf("tbl%0d rdata", i), 64'(req_rdata), 64'(tbl[i].erd));
      chk($sformatf("tbl%0d addr", i), 64'(accel_mem_addr), 64'(tbl[i].ea));
      chk($sformatf("tbl%0d err", i), 64'(req_err), 64'h0);
      tick();
    end

    // single CPU write, ready in the first BUSY cycle
    do_reset();
    t_addr[2] = 32'h0200_0010; t_wdata[2] = 32'h1234_5678; t_wstrb[2] = 4'hF;
    req_valid = 3'b100; req_write = 3'b100;
    @(negedge clk);
    chk("cpuw N valid", 64'(accel_mem_valid), 64'h0);
    tick();
    accel_mem_ready = 1'b1;
    @(negedge clk);
    chk("cpuw N+1 valid", 64'(accel_mem_valid), 64'h1);
    chk("cpuw payload", {accel_mem_addr, accel_mem_wdata}, 64'h0200_0010_1234_5678);
    chk("cpuw wstrb/write", {59'h0, accel_mem_wstrb, accel_mem_write}, 64'h1F);
    chk("cpuw grant", 64'(grant_id), 64'd2);
    chk("cpuw ready", 64'(req_ready), 64'b100);
    chk("cpuw err", 64'(req_err), 64'h0);
    tick();
    req_valid = '0; req_write = '0; accel_mem_ready = 1'b0;
    @(negedge clk);
    chk("cpuw after grant", 64'(grant_id), 64'd3);
    chk("cpuw after ready", 64'(req_ready), 64'h0);
    chk("cpuw after valid", 64'(accel_mem_valid), 64'h0);

    // starvation: DMA streams, CPU must win after exactly STARV losses
    do_reset();
    req_valid = 3'b101; accel_mem_ready = 1'b1;
    dma_grants = 0; cpu_seen = 0;
    for (int k = 0; k < 200 && !cpu_seen; k++) begin
      @(negedge clk);
      if (accel_mem_valid && grant_id == 2'd0) dma_grants++;
      if (accel_mem_valid && grant_id == 2'd2) begin
        cpu_seen = 1;
        chk("starve cpu ready", 64'(req_ready), 64'b100);
      end
      tick();
    end
    chk("starve cpu granted", 64'(cpu_seen), 64'h1);
    chk("starve dma wins before cpu", 64'(dma_grants), 64'(STARV));

    // timeout abort on the 16th BUSY cycle
    do_reset();
    req_valid = 3'b010;
    tick();
    hit = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (req_ready != 3'b000) begin
        hit = k;
        break;
      end
      tick();
    end
    chk("tmo cycle", 64'(hit), 64'(TMO));
    chk("tmo ready", 64'(req_ready), 64'b010);
    chk("tmo err", 64'(req_err), 64'b010);
    chk("tmo rdata", 64'(req_rdata), 64'hDEADBEEF);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("tmo count", 64'(timeout_count), 64'd1);
    chk("tmo port free", {62'h0, accel_mem_valid, busy}, 64'h0);
    chk("tmo grant", 64'(grant_id), 64'd3);

    // ready coincides with the abort cycle: normal completion wins
    tick();
    req_valid = 3'b010;
    tick();
    for (int k = 1; k < TMO; k++) tick();
    accel_mem_ready = 1'b1; accel_mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    chk("race ready", 64'(req_ready), 64'b010);
    chk("race err", 64'(req_err), 64'h0);
    chk("race rdata", 64'(req_rdata), 64'h0BAD_F00D);
    tick();
    req_valid = '0; accel_mem_ready = 1'b0;
    @(negedge clk);
    chk("race count", 64'(timeout_count), 64'd1);
    chk("race valid", 64'(accel_mem_valid), 64'h0);

    // reset during BUSY abandons the transaction
    tick();
    req_valid = 3'b001;
    tick();
    tick();
    @(negedge clk);
    chk("rst pre busy", 64'(accel_mem_valid), 64'h1);
    tick();
    resetn = 1'b0;
    @(negedge clk);
    chk("rst cycle ready", 64'(req_ready), 64'h0);
    tick();
    resetn = 1'b1; req_valid = '0;
    @(negedge clk);
    chk("rst valid", 64'(accel_mem_valid), 64'h0);
    chk("rst grant", 64'(grant_id), 64'd3);
    chk("rst count", 64'(timeout_count), 64'h0);
    chk("rst ready", 64'(req_ready), 64'h0);

    // random traffic against the reference model
    do_reset();
    m_busy = 0; m_g = 3; m_cnt = 0; m_tcnt = 0;
    for (int i = 0; i < 3; i++) begin
      m_starve[i] = 0; mv[i] = 0; dropped[i] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (!mv[i] && !dropped[i] && $urandom_range(0, 2) == 0) begin
          mv[i] = 1;
          req_write[i] = 1'($urandom);
          t_addr[i] = $urandom;
          t_wdata[i] = $urandom;
          t_wstrb[i] = 4'($urandom);
        end
        dropped[i] = 0;
        req_valid[i] = mv[i];
      end
      accel_mem_ready = ($urandom_range(0, 9) == 0);
      accel_mem_rdata = $urandom;
      @(negedge clk);
      fin = m_busy && (accel_mem_ready || m_cnt == TMO - 1);
      e_ready = fin ? (3'b001 << m_g) : 3'b000;
      e_err   = (fin && !accel_mem_ready) ? (3'b001 << m_g) : 3'b000;
      e_rdata = !fin ? 32'h0 : (accel_mem_ready ? accel_mem_rdata : 32'hDEADBEEF);
      chk("rnd valid/grant", {61'h0, accel_mem_valid, grant_id},
          {61'h0, m_busy, (m_busy ? 2'(m_g) : 2'd3)});
      chk("rnd addr/wdata", {accel_mem_addr, accel_mem_wdata},
          m_busy ? {m_addr, m_wdata} : 64'h0);
      chk("rnd wstrb/write", {59'h0, accel_mem_wstrb, accel_mem_write},
          m_busy ? {59'h0, m_wstrb, m_write} : 64'h0);
      chk("rnd ready/err", {58'h0, req_ready, req_err}, {58'h0, e_ready, e_err});
      chk("rnd rdata", 64'(req_rdata), 64'(e_rdata));
      chk("rnd tcount", 64'(timeout_count), 64'(m_tcnt));
      if (m_busy) begin
        if (fin) begin
          if (!accel_mem_ready && m_tcnt < 255) m_tcnt++;
          mv[m_g] = 0;
          dropped[m_g] = 1;
          m_busy = 0;
        end else begin
          m_cnt++;
        end
      end else if (mv[0] || mv[1] || mv[2]) begin
        m_w = -1;
        for (int i = 0; i < 3; i++)
          if (m_w < 0 && mv[i] && m_starve[i] >= STARV) m_w = i;
        for (int i = 0; i < 3; i++)
          if (m_w < 0 && mv[i]) m_w = i;
        for (int i = 0; i < 3; i++) begin
          if (i == m_w) m_starve[i] = 0;
          else if (mv[i] && m_starve[i] < STARV) m_starve[i]++;
        end
        m_g = m_w; m_busy = 1; m_cnt = 0;
        m_addr = t_addr[m_w]; m_wdata = t_wdata[m_w];
        m_wstrb = t_wstrb[m_w]; m_write = req_write[m_w];
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/accel_port_arbiter.md
Name: accel_port_arbiter

Overview:
Arbitrates the single accelerator MMIO port between three requesters: on-chip DMA engine (index 0), custom-PCPI command latch (index 1) and CPU pass-through (index 2). It replaces the ad-hoc priority mux in front of accelerator_wrapper. Grants are held per transaction until the accelerator handshakes. Anti-starvation aging and a bus timeout ensure that no requester can lock up the SoC.

Parameters:
TIMEOUT_CYCLES, 256, cycles in BUSY without accel_mem_ready before the transaction is aborted (range 2..65535)
STARVE_LIMIT, 8, lost arbitrations after which a requester is promoted to top priority (range 1..255)

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
req_valid  in  3  per-requester request; must stay stable until its req_ready
req_write  in  3  per-requester write flag
req_addr  in  96  per-requester byte address; requester i occupies bits [32i+31:32i]
req_wdata  in  96  per-requester write data, packed the same way as req_addr
req_wstrb  in  12  per-requester byte strobes; requester i occupies bits [4i+3:4i]
req_ready  out  3  one-cycle completion pulse to the granted requester
req_err  out  3  qualifies req_ready; high means the transaction timed out
req_rdata  out  32  read data, shared and valid with req_ready
accel_mem_valid  out  1  to accelerator_wrapper
accel_mem_write  out  1  to accelerator_wrapper
accel_mem_addr  out  32  to accelerator_wrapper
accel_mem_wdata  out  32  to accelerator_wrapper
accel_mem_wstrb  out  4  to accelerator_wrapper
accel_mem_rdata  in  32  from accelerator_wrapper
accel_mem_ready  in  1  from accelerator_wrapper
grant_id  out  2  currently granted index; 2'd3 when idle
busy  out  1  high in BUSY
timeout_count  out  8  saturating count of aborted transactions

Behaviour:
- Reset (resetn low at a clk edge): state IDLE and all counters cleared. Outputs after reset: accel_mem_* = 0, req_ready = 0, req_err = 0, req_rdata = 0, grant_id = 3, busy = 0, timeout_count = 0. Reset asserted mid-transaction abandons it silently, with no req_ready.
- FSM has two states, IDLE and BUSY.
- IDLE, when any req_valid is high:
  - Pick a winner.
  - Latch its write, addr, wdata and wstrb into the payload registers.
  - Set grant_id and go to BUSY.
- Winner selection:
  - Among requesters whose starve counter has reached STARVE_LIMIT, the lowest index wins.
  - Otherwise fixed priority applies: 0 > 1 > 2.
- BUSY: accel_mem_valid = 1, and accel_mem_* come from the payload registers (registered; no combinational path from req_* to accel_mem_*).
- Latency: request valid in cycle N gives accel_mem_valid in cycle N+1. The minimum transaction occupies the port for 2 cycles.
- Completion in BUSY:
  - When accel_mem_ready = 1 in cycle M, req_ready[grant_id] = 1 and req_rdata = accel_mem_rdata, both combinational in cycle M.
  - In cycle M+1 the FSM is back in IDLE and accel_mem_valid = 0.
  - The requester drops valid at M+1, so its finished request is never re-granted.
- req_rdata is 0 whenever no req_ready is high.
- Starve counters (8-bit, one per requester):
  - On each IDLE arbitration, every valid non-winner increments its counter, saturating at STARVE_LIMIT.
  - The winner's counter clears.
  - Counters hold while in BUSY.
- Timeout counter:
  - Cleared on entry to BUSY and increments each BUSY cycle.
  - Abort fires when the count equals TIMEOUT_CYCLES-1 with accel_mem_ready low.
  - On abort, in that cycle: req_ready[g] = 1, req_err[g] = 1, req_rdata = 32'hDEADBEEF.
  - timeout_count increments, saturating at 255. The FSM returns to IDLE and accel_mem_valid drops the next cycle.
- If accel_mem_ready arrives in the same cycle as the abort condition, normal completion wins with no error.
- Requester rule: a requester that drops req_valid while granted is ignored. The transaction completes to the accelerator and req_ready is still pulsed.
- Simultaneous new requests during BUSY wait; they are not queued beyond their own held valid.

Decomposition:
- Package accel_arb_pkg contains:
  - REQ_DMA = 0, REQ_PCPI = 1, REQ_CPU = 2, NUM_REQ = 3
  - GRANT_NONE = 2'd3
  - ERR_RDATA = 32'hDEADBEEF
  - state enum arb_state_t {ARB_IDLE, ARB_BUSY}
- Sub-module arb_starve_ctr holds one per-requester saturating counter, with inputs lost and won and output starved. It is instantiated NUM_REQ times.

Test Plan:
- Single CPU write, addr 0x02000010, data 0x12345678, accelerator ready 1 cycle after valid -> accel_mem_valid seen cycle N+1 with matching payload; req_ready[2] pulses once; req_err = 0; grant_id returns to 3.
- DMA and CPU request in the same cycle -> DMA granted first; CPU granted at the next IDLE; CPU starve counter 1 then cleared.
- DMA holds req_valid continuously with 9 back-to-back transactions while CPU waits, STARVE_LIMIT = 8 -> CPU granted after exactly 8 lost arbitrations, ahead of the pending DMA request.
- accel_mem_ready tied low, TIMEOUT_CYCLES = 16 -> req_ready[1] and req_err[1] pulse at the 16th BUSY cycle with req_rdata = 0xDEADBEEF; timeout_count = 1; port free the next cycle.
- accel_mem_ready rises exactly on the abort cycle -> normal completion; req_err = 0; timeout_count unchanged.
- resetn low for 1 cycle mid-BUSY -> next cycle accel_mem_valid = 0, grant_id = 3, no req_ready pulse, all counters 0.
